fp_mul_seq: RTL and testbench
=============================

// Module: fp_mul_seq
// PURPOSE
// - Multi-cycle IEEE-style floating-point multiplier; the consumer stage behind operand/operation classification.
// - Resolves special cases (NaN, Inf, zero, Inf*0) in one cycle.
// - Finite operands go through a shift-add mantissa multiplier and a normaliser.
// - valid/ready on both sides; one operation in flight.
// PARAMETERS
// - EXP_WIDTH   8   exponent field width; bias = 2**(EXP_WIDTH-1)-1
// - MANT_WIDTH  23  stored mantissa width; hidden bit implicit
// PORTS
// - clk        in   1                      single clock, rising edge
// - rst        in   1                      synchronous, active-high reset
// - in_valid   in   1                      op1/op2 valid
// - in_ready   out  1                      block can accept (IDLE only)
// - op1        in   EXP_WIDTH+MANT_WIDTH+1 [sign][exp][mantissa]
// - op2        in   EXP_WIDTH+MANT_WIDTH+1 [sign][exp][mantissa]
// - out_valid  out  1                      result/flags valid
// - out_ready  in   1                      consumer accepts result
// - result     out  EXP_WIDTH+MANT_WIDTH+1 product
// - flags      out  4                      {nan_in, invalid, overflow, underflow}
// BEHAVIOUR
// - Reset: state=IDLE; in_ready=1, out_valid=0, result=0, flags=0.
// - rst inside any state aborts the operation; no output is produced for it.
// - FSM: IDLE -> CLASS -> (DONE | MUL -> NORM -> DONE) -> IDLE.
// - IDLE: in_ready=1. in_valid&&in_ready latches op1/op2 and goes to CLASS. in_ready=0 in every other state.
// - CLASS (1 cycle): classify both operands.
//   - Denormals are flushed to zero and treated as zero; no flag is raised for them.
//   - sign_r = s1^s2.
//   - Priority: any NaN -> canonical qNaN {0,all-1 exp,1,0...}, nan_in=1.
//   - Inf*zero -> qNaN, invalid=1.
//   - any Inf -> {sign_r,all-1,0}.
//   - any zero -> {sign_r,0,0}.
//   - Special results go straight to DONE.
//   - Otherwise: exp_r = e1+e2-bias, signed, EXP_WIDTH+2 bits; load mantissas {1,m}; go to MUL.
// - MUL: exactly MANT_WIDTH+1 cycles of shift-add. Counter counts 0..MANT_WIDTH.
//   - Product register is 2*(MANT_WIDTH+1) bits; the counter's last value goes to NORM.
// - NORM (1 cycle):
//   - If product MSB=1: take mantissa bits below the MSB; exp_r+1. Else take bits below MSB-1.
//   - Truncate (round toward zero); no sticky bit.
//   - exp >= all-1 -> {sign_r,all-1,0}, overflow=1.
//   - exp <= 0 -> {sign_r,0,0}, underflow=1.
//   - Otherwise pack the normal result.
// - DONE: out_valid=1. result/flags are held stable while out_ready=0.
//   - On out_valid&&out_ready: out_valid=0 and return to IDLE. The next op can be accepted the cycle after.
//   - There is no accept in the same cycle as the output handshake.
// - Latency, from the accept edge to out_valid high:
//   - special case: 2 cycles.
//   - finite case: MANT_WIDTH+4 cycles (27 at defaults).
// - flags bits are mutually exclusive per op and are cleared when the next op is accepted.
// - result is not combinational from the inputs; every output is registered.
// TESTING
// - 0x40000000*0x40400000 -> 0x40C00000, flags=0, out_valid 27 cycles after accept.
// - 0x3FC00000*0x3FC00000 (normalise path) -> 0x40100000, flags=0.
// - 0x7F800000*0x00000000 -> 0x7FC00000, flags=4'b0100, latency 2.
// - 0x7FC00001*0x3F800000 -> 0x7FC00000, flags=4'b1000.
//   0xFF800000*0x40000000 -> 0xFF800000, flags=0.
// - 0x7F000000*0x7F000000 -> 0x7F800000, flags=4'b0010.
//   0x00800000*0x80800000 -> 0x80000000, flags=4'b0001.
// - Backpressure: out_ready=0 for 5 cycles -> result stable, in_ready=0.
//   - Assert rst mid-MUL -> next cycle in_ready=1, out_valid=0.
//   - A new op after reset returns its correct result.

Source files
------------

// File: rtl/fp_mul_seq_if.sv
// Operand/result handshake bundle for fp_mul_seq.
// master = producer/consumer side, slave = the multiplier.
interface fp_mul_seq_if #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23
);
  localparam int W = EXP_WIDTH + MANT_WIDTH + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, op1, op2, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op1, op2, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_mul_seq.sv
// Multi-cycle floating-point multiplier: one-cycle special-case resolution,
// shift-add mantissa product, truncating normaliser. One operation in flight.
module fp_mul_seq #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23
) (
  input  logic        clk,
  input  logic        rst,
  fp_mul_seq_if.slave bus
);
  localparam int W  = EXP_WIDTH + MANT_WIDTH + 1;
  localparam int PW = 2 * (MANT_WIDTH + 1);
  localparam int XW = EXP_WIDTH + 2;
  localparam int CW = $clog2(MANT_WIDTH + 1);
  localparam logic signed [XW-1:0] BIAS    = XW'((2 ** (EXP_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = {2'b00, {EXP_WIDTH{1'b1}}};
  localparam logic [CW-1:0]        CNT_END = CW'(MANT_WIDTH);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_CLASS, S_MUL, S_NORM, S_DONE} state_t;

  state_t                  r_state;
  logic [W-1:0]            r_op1, r_op2;
  logic                    r_sign;
  logic signed [XW-1:0]    r_exp;
  logic [PW-1:0]           r_mcand;
  logic [MANT_WIDTH:0]     r_mplier;
  logic [PW-1:0]           r_prod;
  logic [CW-1:0]           r_cnt;
  logic [W-1:0]            r_res;
  logic [3:0]              r_flag;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [W-1:0]            r_result;
  logic [3:0]              r_flags;

  logic [EXP_WIDTH-1:0]    w_e1, w_e2;
  logic [MANT_WIDTH-1:0]   w_m1, w_m2;
  logic                    w_zero1, w_zero2, w_inf1, w_inf2, w_nan1, w_nan2;
  logic signed [XW-1:0]    w_exp_n;
  logic [MANT_WIDTH-1:0]   w_mant_n;
  logic                    w_ovf, w_unf;

  assign w_e1 = r_op1[W-2:MANT_WIDTH];
  assign w_e2 = r_op2[W-2:MANT_WIDTH];
  assign w_m1 = r_op1[MANT_WIDTH-1:0];
  assign w_m2 = r_op2[MANT_WIDTH-1:0];

  // Denormals (exp==0) count as zero; all-ones exponent splits into Inf/NaN.
  assign w_zero1 = (w_e1 == {EXP_WIDTH{1'b0}});
  assign w_zero2 = (w_e2 == {EXP_WIDTH{1'b0}});
  assign w_inf1  = (w_e1 == {EXP_WIDTH{1'b1}}) && (w_m1 == {MANT_WIDTH{1'b0}});
  assign w_inf2  = (w_e2 == {EXP_WIDTH{1'b1}}) && (w_m2 == {MANT_WIDTH{1'b0}});
  assign w_nan1  = (w_e1 == {EXP_WIDTH{1'b1}}) && (w_m1 != {MANT_WIDTH{1'b0}});
  assign w_nan2  = (w_e2 == {EXP_WIDTH{1'b1}}) && (w_m2 != {MANT_WIDTH{1'b0}});

  // Normaliser: product of two [1,2) mantissas lies in [1,4).
  always_comb begin
    w_exp_n  = r_exp;
    w_mant_n = r_prod[2*MANT_WIDTH-1:MANT_WIDTH];
    if (r_prod[PW-1]) begin
      w_exp_n  = r_exp + XW'(1);
      w_mant_n = r_prod[2*MANT_WIDTH:MANT_WIDTH+1];
    end else begin
      w_exp_n  = r_exp;
      w_mant_n = r_prod[2*MANT_WIDTH-1:MANT_WIDTH];
    end
  end

  assign w_ovf = (w_exp_n >= EXP_MAX);
  assign w_unf = (w_exp_n <= $signed({XW{1'b0}}));

  // Control FSM plus datapath; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op1       <= '0;
      r_op2       <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_prod      <= '0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_flag      <= 4'b0000;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= 4'b0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_op1      <= bus.op1;
            r_op2      <= bus.op2;
            r_in_ready <= 1'b0;
            r_flags    <= 4'b0000;
            r_state    <= S_CLASS;
          end
        end
        S_CLASS: begin
          r_sign <= r_op1[W-1] ^ r_op2[W-1];
          r_flag <= 4'b0000;
          r_state <= S_DONE;
          if (w_nan1 || w_nan2) begin
            r_res  <= QNAN;
            r_flag <= 4'b1000;
          end else if ((w_inf1 && w_zero2) || (w_zero1 && w_inf2)) begin
            r_res  <= QNAN;
            r_flag <= 4'b0100;
          end else if (w_inf1 || w_inf2) begin
            r_res <= {r_op1[W-1] ^ r_op2[W-1], {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
          end else if (w_zero1 || w_zero2) begin
            r_res <= {r_op1[W-1] ^ r_op2[W-1], {(W-1){1'b0}}};
          end else begin
            r_exp    <= $signed({2'b00, w_e1}) + $signed({2'b00, w_e2}) - BIAS;
            r_mcand  <= {{(MANT_WIDTH+1){1'b0}}, 1'b1, w_m1};
            r_mplier <= {1'b1, w_m2};
            r_prod   <= '0;
            r_cnt    <= '0;
            r_state  <= S_MUL;
          end
        end
        S_MUL: begin
          if (r_mplier[0]) begin
            r_prod <= r_prod + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CNT_END) begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (w_ovf) begin
            r_res  <= {r_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            r_flag <= 4'b0010;
          end else if (w_unf) begin
            r_res  <= {r_sign, {(W-1){1'b0}}};
            r_flag <= 4'b0001;
          end else begin
            r_res  <= {r_sign, w_exp_n[EXP_WIDTH-1:0], w_mant_n};
            r_flag <= 4'b0000;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_result    <= r_res;
            r_flags     <= r_flag;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed self-checking bench for fp_mul_seq with hand-computed vectors.
module tb_fp_mul_seq;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  fp_mul_seq_if #(.EXP_WIDTH(8), .MANT_WIDTH(23)) bus ();

  fp_mul_seq #(.EXP_WIDTH(8), .MANT_WIDTH(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Accept one op, measure latency, check result/flags, optionally hold out_ready low.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [3:0] exp_flags,
                        input int exp_lat, input int hold);
    int lat;
    int guard;
    guard = 0;
    bus.out_ready = (hold == 0);
    while (!bus.in_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op1      = a;
    bus.op2      = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_res"}, bus.result, exp_res);
    check_eq({tag, "_flags"}, 32'(bus.flags), 32'(exp_flags));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_res"}, bus.result, exp_res);
      check_eq({tag, "_hold_vld"}, 32'(bus.out_valid), 32'd1);
      check_eq({tag, "_hold_rdy"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op1       = 32'h0;
    bus.op2       = 32'h0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_result", bus.result, 32'h0);
    check_eq("rst_flags", 32'(bus.flags), 32'd0);

    run_op("mul2x3",    32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 27, 0);
    run_op("norm1p5",   32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 27, 0);
    run_op("inf_x0",    32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b0100,  2, 0);
    run_op("nan_in",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000,  2, 0);
    run_op("ninf_x2",   32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000,  2, 0);
    run_op("overflow",  32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0010, 27, 0);
    run_op("underflow", 32'h00800000, 32'h80800000, 32'h80000000, 4'b0001, 27, 0);
    run_op("one_x_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 27, 0);
    run_op("neg2x3",    32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 27, 0);
    run_op("denorm",    32'h00400000, 32'h40000000, 32'h00000000, 4'b0000,  2, 0);
    run_op("nan_vs_0",  32'h7FC00000, 32'h00000000, 32'h7FC00000, 4'b1000,  2, 0);
    run_op("inf_x_n0",  32'h7F800000, 32'h80000000, 32'h7FC00000, 4'b0100,  2, 0);
    run_op("backpres",  32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 27, 5);

    // Abort an operation part-way through the shift-add phase.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op1      = 32'h40000000;
    bus.op2      = 32'h40400000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    check_eq("abort_no_output", 32'(bus.out_valid), 32'd0);

    run_op("post_rst",  32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 27, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
